uart_rx_deserializer: RTL and testbench

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

---
 rtl/uart_rx_deserializer.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver, LSB first; `define RX_PARITY_EN adds an even-parity bit.
// d_ready pulses one clk after the stop-bit mid-sample; no backpressure, outputs hold until the next frame.
module uart_rx_deserializer #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             rx,
  output logic [WIDTH-1:0] d_out,
  output logic             d_ready,
  output logic             p_error,
  output logic             f_error,
  output logic             busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [CW-1:0]    r_tick_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_armed;
  logic [WIDTH-1:0] r_dout;
  logic             r_dready;
  logic             r_ferr;
  logic             r_busy;
  logic             w_mid_start;
  logic             w_mid_bit;
  logic             w_cnt_clr;
  logic             w_shift_en;
  logic             w_done;
`ifdef RX_PARITY_EN
  logic             w_par_cap;
  logic             r_perr_pend;
  logic             r_perr;
`endif

  assign w_mid_start = baud_tick && (r_tick_cnt == MID_START);
  assign w_mid_bit   = baud_tick && (r_tick_cnt == MID_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
`ifdef RX_PARITY_EN
    w_par_cap   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (baud_tick && r_armed && !r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        // Realign the counter at the start-bit centre so data samples land mid-bit.
        if (w_mid_start) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_mid_bit) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (w_mid_bit) begin
          w_par_cap   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_mid_bit) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_tick_cnt <= '0;
      end else if (baud_tick) begin
        r_tick_cnt <= (r_tick_cnt == MID_BIT) ? '0 : r_tick_cnt + CW'(1);
      end
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_rx_s, r_shift[WIDTH-1:1]};
    end
  end

  // A low stop bit disarms start detection until the line has been seen high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b1;
    end else if (w_done) begin
      r_armed <= r_rx_s;
    end else if ((r_state == S_IDLE) && baud_tick && r_rx_s) begin
      r_armed <= 1'b1;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr_pend <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      if (w_par_cap) begin
        r_perr_pend <= (r_rx_s != (^r_shift));
      end
      if (w_done) begin
        r_perr <= r_perr_pend;
      end
    end
  end

  assign p_error = r_perr;
`else
  assign p_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout   <= '0;
      r_dready <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_dready <= w_done;
      if (w_done) begin
        r_dout <= r_shift;
        r_ferr <= ~r_rx_s;
      end
    end
  end

  assign d_out   = r_dout;
  assign d_ready = r_dready;
  assign f_error = r_ferr;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized bench for uart_rx_deserializer: frames built bit by bit from data words and
// compared against a queue of expected (data, parity error, framing error) results.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int WIDTH = 8;
  localparam int OS    = 16;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             baud_tick = 1'b0;
  logic             rx = 1'b1;
  logic [WIDTH-1:0] d_out;
  logic             d_ready;
  logic             p_error;
  logic             f_error;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             pe;
    logic             fe;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             e_pop;
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_pe = 1'b0;
  logic             m_fe = 1'b0;
  logic             rst_prev = 1'b1;
  logic             prev_rdy = 1'b0;

  uart_rx_deserializer #(.WIDTH(WIDTH), .OVERSAMPLE(OS)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .rx       (rx),
    .d_out    (d_out),
    .d_ready  (d_ready),
    .p_error  (p_error),
    .f_error  (f_error),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Irregular tick spacing exercises stall tolerance between ticks.
  initial begin
    forever begin
      repeat ($urandom_range(2, 5)) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic bad_par, input logic stop_b);
    exp_t e;
    e.d  = d;
    e.pe = PAR_EN & bad_par;
    e.fe = ~stop_b;
    exp_q.push_back(e);
    send_bit(1'b0, OS);
    for (int i = 0; i < WIDTH; i++) send_bit(d[i], OS);
    if (PAR_EN) send_bit((^d) ^ bad_par, OS);
    send_bit(stop_b, OS);
  endtask

  // Output monitor: every d_ready must match the oldest expected frame; otherwise outputs hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        m_dout = '0;
        m_pe   = 1'b0;
        m_fe   = 1'b0;
        exp_q.delete();
      end
      if (d_ready) begin
        chk("dready_width", prev_rdy, 1'b0);
        if (exp_q.size() == 0) begin
          chk("dready_unexp", d_ready, 1'b0);
        end else begin
          e_pop  = exp_q.pop_front();
          m_dout = e_pop.d;
          m_pe   = e_pop.pe;
          m_fe   = e_pop.fe;
          chk("d_out", d_out, m_dout);
          chk("p_error", p_error, m_pe);
          chk("f_error", f_error, m_fe);
        end
      end else begin
        chk("dout_hold", d_out, m_dout);
        chk("perr_hold", p_error, m_pe);
        chk("ferr_hold", f_error, m_fe);
      end
      prev_rdy = d_ready;
      rst_prev = rst;
    end
  end

  initial begin
    logic [WIDTH-1:0] rd;
    logic             rbp;
    logic             rsb;
    logic [WIDTH-1:0] ab;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_out", d_out, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_p_error", p_error, 0);
    chk("rst_f_error", f_error, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    send_bit(1'b1, OS);

    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1, 4);

    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    send_bit(1'b1, OS);

    // Low stop bit followed by a held-low line must not start a new frame.
    send_frame(8'h55, 1'b0, 1'b0);
    send_bit(1'b0, 2 * OS);
    chk("brk_busy", busy, 0);
    send_bit(1'b1, OS);

    rx = 1'b0;
    repeat (2) wait_tick();
    chk("glitch_busy", busy, 1);
    repeat (OS / 4 - 2) wait_tick();
    rx = 1'b1;
    repeat (OS / 2) wait_tick();
    chk("glitch_idle", busy, 0);
    send_bit(1'b1, OS);

    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b1);
    send_bit(1'b1, OS);

    // Abort mid-frame during data bit 4.
    ab = 8'hC3;
    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(ab[i], OS);
    rx = ab[4];
    repeat (OS / 2) wait_tick();
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_d_out", d_out, 0);
    chk("abort_d_ready", d_ready, 0);
    chk("abort_p_error", p_error, 0);
    chk("abort_f_error", f_error, 0);
    chk("abort_busy_rst", busy, 0);
    rst = 1'b0;
    send_bit(1'b1, OS);
    send_frame(8'h7E, 1'b0, 1'b1);
    send_bit(1'b1, OS);

    for (int k = 0; k < 25; k++) begin
      rd  = WIDTH'($urandom);
      rbp = ($urandom_range(0, 3) == 0);
      rsb = ($urandom_range(0, 4) != 0);
      send_frame(rd, rbp, rsb);
      if (!rsb) send_bit(1'b1, OS);
      send_bit(1'b1, $urandom_range(0, 2 * OS));
    end

    send_bit(1'b1, 2 * OS);
    chk("pending_frames", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
